// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use detection and a
// per-register latency scoreboard for a single multi-cycle execution unit.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_AW-1:0]    RsIF2ID,
    input  logic [REG_AW-1:0]    RtIF2ID,
    input  logic                 RsUsedIF2ID,
    input  logic                 RtUsedIF2ID,
    input  logic [REG_AW-1:0]    RsID2EX,
    input  logic [REG_AW-1:0]    RtID2EX,
    input  logic [REG_AW-1:0]    WriteRegisterID2EX,
    input  logic                 MemReadID2EX,
    input  logic [REG_AW-1:0]    WriteRegisterEX2MEM,
    input  logic                 RegWriteEX2MEM,
    input  logic [REG_AW-1:0]    WriteRegisterMEM2WB,
    input  logic                 RegWriteMEM2WB,
    input  logic                 McIssue,
    input  logic [REG_AW-1:0]    McDest,
    input  logic [LAT_W-1:0]     McLat,
    output logic [1:0]           ForwardA,
    output logic [1:0]           ForwardB,
    output logic                 Stall,
    output logic                 McBusy,
    output logic [2**REG_AW-1:0] Pending,
    output logic                 McIssueErr,
    output logic [PERF_W-1:0]    StallCount
);
    localparam int NREG = 2**REG_AW;

    logic [LAT_W-1:0]  cnt_r [NREG];
    logic [LAT_W-1:0]  busy_r;
    logic              err_r;
    logic [PERF_W-1:0] stall_cnt_r;
    logic [NREG-1:0]   pending_s;
    logic              legal_issue_s;
    logic              illegal_issue_s;
    logic              load_use_s;
    logic              sb_hazard_s;

    // The nearer (EX/MEM) producer wins over MEM/WB; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] mem_dst,
        input logic              mem_we,
        input logic [REG_AW-1:0] wb_dst,
        input logic              wb_we
    );
        logic [1:0] sel;
        if (mem_we && (mem_dst != {REG_AW{1'b0}}) && (mem_dst == src)) begin
            sel = 2'd1;
        end else if (wb_we && (wb_dst != {REG_AW{1'b0}}) && (wb_dst == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Combinational operand forwarding selects
    always_comb begin
        ForwardA = fwd_sel(RsID2EX, WriteRegisterEX2MEM, RegWriteEX2MEM,
                           WriteRegisterMEM2WB, RegWriteMEM2WB);
        ForwardB = fwd_sel(RtID2EX, WriteRegisterEX2MEM, RegWriteEX2MEM,
                           WriteRegisterMEM2WB, RegWriteMEM2WB);
    end

    // Pending bits, issue legality and stall decision
    always_comb begin
        pending_s = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            pending_s[r] = (cnt_r[r] != {LAT_W{1'b0}});
        end
        McBusy          = (busy_r != {LAT_W{1'b0}});
        legal_issue_s   = McIssue && !McBusy && (McLat != {LAT_W{1'b0}});
        illegal_issue_s = McIssue && (McBusy || (McLat == {LAT_W{1'b0}}));
        load_use_s = MemReadID2EX && (WriteRegisterID2EX != {REG_AW{1'b0}}) &&
                     ((RsUsedIF2ID && (RsIF2ID == WriteRegisterID2EX)) ||
                      (RtUsedIF2ID && (RtIF2ID == WriteRegisterID2EX)));
        sb_hazard_s = (RsUsedIF2ID && (RsIF2ID != {REG_AW{1'b0}}) && pending_s[RsIF2ID]) ||
                      (RtUsedIF2ID && (RtIF2ID != {REG_AW{1'b0}}) && pending_s[RtIF2ID]);
        Stall      = load_use_s || sb_hazard_s;
        Pending    = pending_s;
        McIssueErr = err_r;
        StallCount = stall_cnt_r;
    end

    // Per-register latency counters; r0 is tied to zero so it never blocks
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst || (r == 0)) begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end else if (legal_issue_s && (McDest == REG_AW'(r))) begin
                cnt_r[r] <= McLat;
            end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
                cnt_r[r] <= cnt_r[r] - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r[r] <= cnt_r[r];
            end
        end
    end

    // Unit occupancy counter, loaded on every legal issue including dest r0
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {LAT_W{1'b0}};
        end else if (legal_issue_s) begin
            busy_r <= McLat;
        end else if (busy_r != {LAT_W{1'b0}}) begin
            busy_r <= busy_r - {{(LAT_W-1){1'b0}}, 1'b1};
        end else begin
            busy_r <= busy_r;
        end
    end

    // Sticky illegal-issue flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (illegal_issue_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {PERF_W{1'b0}};
        end else if (Stall && (stall_cnt_r != {PERF_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: forwarding/hazard vector table
// checked through an expectation queue, plus multi-cycle scoreboard sequences.
module tb_hazard_fwd_unit;
    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;
    localparam int PERF_W = 16;
    localparam int NREG   = 2**REG_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] RsIF2ID, RtIF2ID, RsID2EX, RtID2EX;
    logic              RsUsedIF2ID, RtUsedIF2ID;
    logic [REG_AW-1:0] WriteRegisterID2EX, WriteRegisterEX2MEM, WriteRegisterMEM2WB;
    logic              MemReadID2EX, RegWriteEX2MEM, RegWriteMEM2WB;
    logic              McIssue;
    logic [REG_AW-1:0] McDest;
    logic [LAT_W-1:0]  McLat;
    logic [1:0]        ForwardA, ForwardB;
    logic              Stall, McBusy, McIssueErr;
    logic [NREG-1:0]   Pending;
    logic [PERF_W-1:0] StallCount;

    int n_pass  = 0;
    int n_total = 0;

    hazard_fwd_unit #(.REG_AW(REG_AW), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .RsIF2ID(RsIF2ID), .RtIF2ID(RtIF2ID),
        .RsUsedIF2ID(RsUsedIF2ID), .RtUsedIF2ID(RtUsedIF2ID),
        .RsID2EX(RsID2EX), .RtID2EX(RtID2EX),
        .WriteRegisterID2EX(WriteRegisterID2EX), .MemReadID2EX(MemReadID2EX),
        .WriteRegisterEX2MEM(WriteRegisterEX2MEM), .RegWriteEX2MEM(RegWriteEX2MEM),
        .WriteRegisterMEM2WB(WriteRegisterMEM2WB), .RegWriteMEM2WB(RegWriteMEM2WB),
        .McIssue(McIssue), .McDest(McDest), .McLat(McLat),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall),
        .McBusy(McBusy), .Pending(Pending), .McIssueErr(McIssueErr),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_AW-1:0] rs_ex, rt_ex, mem_dst, wb_dst;
        logic              mem_we, wb_we;
        logic [REG_AW-1:0] rs_if, rt_if, ld_dst;
        logic              rs_used, rt_used, mem_rd;
        logic [1:0]        exp_fa, exp_fb;
        logic              exp_stall;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] act);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL queue_empty: got %0h expected queued value", act);
        end else begin
            e = exp_q.pop_front();
            chk(e.name, act, e.val);
        end
    endtask

    // Advance one rising edge; inputs are then driven 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RsIF2ID = '0; RtIF2ID = '0; RsUsedIF2ID = 1'b0; RtUsedIF2ID = 1'b0;
        RsID2EX = '0; RtID2EX = '0; WriteRegisterID2EX = '0; MemReadID2EX = 1'b0;
        WriteRegisterEX2MEM = '0; RegWriteEX2MEM = 1'b0;
        WriteRegisterMEM2WB = '0; RegWriteMEM2WB = 1'b0;
        McIssue = 1'b0; McDest = '0; McLat = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] d, input logic [LAT_W-1:0] l);
        McIssue = 1'b1; McDest = d; McLat = l;
    endtask

    initial begin
        // rs_ex rt_ex mem_dst wb_dst mem_we wb_we rs_if rt_if ld_dst rs_u rt_u mem_rd fa fb stall
        vecs[0] = '{5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd1, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1};
        vecs[1] = '{5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0};
        vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
        vecs[3] = '{5'd9, 5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0};
        vecs[4] = '{5'd5, 5'd6, 5'd5, 5'd6, 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[5] = '{5'd12, 5'd3, 5'd12, 5'd3, 1'b1, 1'b1, 5'd12, 5'd12, 5'd12, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1};
        vecs[6] = '{5'd31, 5'd30, 5'd30, 5'd31, 1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0};
        vecs[7] = '{5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0};

        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_busy", {31'd0, McBusy}, 32'd0);
        chk("reset_pending", Pending, 32'd0);
        chk("reset_err", {31'd0, McIssueErr}, 32'd0);
        chk("reset_stallcount", {16'd0, StallCount}, 32'd0);

        // Combinational forwarding and load-use table
        for (int i = 0; i < 8; i++) begin
            RsID2EX = vecs[i].rs_ex; RtID2EX = vecs[i].rt_ex;
            WriteRegisterEX2MEM = vecs[i].mem_dst; RegWriteEX2MEM = vecs[i].mem_we;
            WriteRegisterMEM2WB = vecs[i].wb_dst; RegWriteMEM2WB = vecs[i].wb_we;
            RsIF2ID = vecs[i].rs_if; RtIF2ID = vecs[i].rt_if;
            RsUsedIF2ID = vecs[i].rs_used; RtUsedIF2ID = vecs[i].rt_used;
            WriteRegisterID2EX = vecs[i].ld_dst; MemReadID2EX = vecs[i].mem_rd;
            push_exp($sformatf("vec%0d_fwdA", i), {30'd0, vecs[i].exp_fa});
            push_exp($sformatf("vec%0d_fwdB", i), {30'd0, vecs[i].exp_fb});
            push_exp($sformatf("vec%0d_stall", i), {31'd0, vecs[i].exp_stall});
            #1;
            pop_chk({30'd0, ForwardA});
            pop_chk({30'd0, ForwardB});
            pop_chk({31'd0, Stall});
            step();
        end

        // Load-use: one stall cycle, cleared by the bubble
        do_reset();
        MemReadID2EX = 1'b1; WriteRegisterID2EX = 5'd8; RtIF2ID = 5'd8; RtUsedIF2ID = 1'b1;
        #1;
        chk("lu_stall", {31'd0, Stall}, 32'd1);
        step();
        MemReadID2EX = 1'b0;
        #1;
        chk("lu_stall_after_bubble", {31'd0, Stall}, 32'd0);
        chk("lu_stallcount", {16'd0, StallCount}, 32'd1);
        MemReadID2EX = 1'b1; RtUsedIF2ID = 1'b0;
        #1;
        chk("lu_rt_unused", {31'd0, Stall}, 32'd0);

        // Scoreboard: r3 latency 4 stalls a reader of r3 for four cycles
        do_reset();
        issue(5'd3, 3'd4);
        RsIF2ID = 5'd3; RsUsedIF2ID = 1'b1;
        #1;
        chk("sb_no_stall_before_issue", {31'd0, Stall}, 32'd0);
        step();
        McIssue = 1'b0;
        #1;
        chk("sb_pending3", {31'd0, Pending[3]}, 32'd1);
        chk("sb_pending_only3", Pending, 32'h0000_0008);
        chk("sb_busy", {31'd0, McBusy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_stall_c%0d", i), {31'd0, Stall}, 32'd1);
            step();
        end
        #1;
        chk("sb_pending3_clear", {31'd0, Pending[3]}, 32'd0);
        chk("sb_stall_end", {31'd0, Stall}, 32'd0);
        chk("sb_busy_end", {31'd0, McBusy}, 32'd0);
        chk("sb_stallcount", {16'd0, StallCount}, 32'd4);

        // Issue to r0: unit busy for the latency, no pending bit
        do_reset();
        issue(5'd0, 3'd2);
        step();
        McIssue = 1'b0;
        #1;
        chk("r0_busy", {31'd0, McBusy}, 32'd1);
        chk("r0_pending", Pending, 32'd0);
        step();
        chk("r0_busy_c2", {31'd0, McBusy}, 32'd1);
        step();
        chk("r0_busy_done", {31'd0, McBusy}, 32'd0);

        // Illegal issues: zero latency, then issue while busy
        do_reset();
        issue(5'd9, 3'd0);
        step();
        McIssue = 1'b0;
        #1;
        chk("ill_lat0_err", {31'd0, McIssueErr}, 32'd1);
        chk("ill_lat0_busy", {31'd0, McBusy}, 32'd0);
        chk("ill_lat0_pending", Pending, 32'd0);
        do_reset();
        chk("ill_err_reset", {31'd0, McIssueErr}, 32'd0);
        issue(5'd6, 3'd3);
        step();
        issue(5'd7, 3'd5);
        #1;
        chk("ill_busy_e0", {31'd0, McBusy}, 32'd1);
        step();
        McIssue = 1'b0;
        #1;
        chk("ill_busy_err", {31'd0, McIssueErr}, 32'd1);
        chk("ill_busy_pending", Pending, 32'h0000_0040);
        chk("ill_busy_e1", {31'd0, McBusy}, 32'd1);
        step();
        chk("ill_busy_e2", {31'd0, McBusy}, 32'd1);
        step();
        chk("ill_busy_e3", {31'd0, McBusy}, 32'd0);
        chk("ill_pending_e3", Pending, 32'd0);
        issue(5'd9, 3'd0);
        step();
        McIssue = 1'b0;
        step();
        chk("ill_err_held", {31'd0, McIssueErr}, 32'd1);
        chk("ill_lat0_busy2", {31'd0, McBusy}, 32'd0);

        // Reset two cycles into a latency-7 op, with a simultaneous issue
        do_reset();
        issue(5'd4, 3'd7);
        RsIF2ID = 5'd4; RsUsedIF2ID = 1'b1;
        step();
        issue(5'd5, 3'd2);
        step();
        McIssue = 1'b0;
        #1;
        chk("mid_stall_before", {31'd0, Stall}, 32'd1);
        chk("mid_err_before", {31'd0, McIssueErr}, 32'd1);
        rst = 1'b1;
        issue(5'd5, 3'd3);
        step();
        rst = 1'b0;
        McIssue = 1'b0;
        #1;
        chk("mid_pending", Pending, 32'd0);
        chk("mid_busy", {31'd0, McBusy}, 32'd0);
        chk("mid_stall", {31'd0, Stall}, 32'd0);
        chk("mid_err", {31'd0, McIssueErr}, 32'd0);
        chk("mid_stallcount", {16'd0, StallCount}, 32'd0);

        // Saturation of the stall counter
        do_reset();
        MemReadID2EX = 1'b1; WriteRegisterID2EX = 5'd8; RtIF2ID = 5'd8; RtUsedIF2ID = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_pre", {16'd0, StallCount}, 32'h0000_FFFE);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", {16'd0, StallCount}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameters:
- REG_AW, 5, register-address width; NREG = 2**REG_AW.
- LAT_W, 3, multi-cycle latency field width; max latency 2**LAT_W-1.
- PERF_W, 16, stall performance-counter width.

REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- RsIF2ID, RtIF2ID  in  REG_AW  source registers of the instruction in ID.
- RsUsedIF2ID, RtUsedIF2ID  in  1  source actually read.
- RsID2EX, RtID2EX  in  REG_AW  source registers of the instruction in EX.
- WriteRegisterID2EX  in  REG_AW  destination of the instruction in EX.
- MemReadID2EX  in  1  instruction in EX is a load.
- WriteRegisterEX2MEM, RegWriteEX2MEM  in  REG_AW/1  MEM-stage destination/enable.
- WriteRegisterMEM2WB, RegWriteMEM2WB  in  REG_AW/1  WB-stage destination/enable.
- McIssue  in  1  multi-cycle op issues from EX this cycle.
- McDest  in  REG_AW  its destination.
- McLat  in  LAT_W  its latency in cycles.
- ForwardA, ForwardB  out  2  EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB.
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- McBusy  out  1  multi-cycle unit occupied.
- Pending  out  NREG  per-register scoreboard pending bits.
- McIssueErr  out  1  sticky illegal-issue flag.
- StallCount  out  PERF_W  saturating count of stall cycles.

Function
REQ-003 ForwardA SHALL be 1 when RegWriteEX2MEM && WriteRegisterEX2MEM!=0 && WriteRegisterEX2MEM==RsID2EX.
REQ-004 Otherwise, ForwardA SHALL be 2 when RegWriteMEM2WB && WriteRegisterMEM2WB!=0 && WriteRegisterMEM2WB==RsID2EX.
REQ-005 Otherwise, ForwardA SHALL be 0.
REQ-006 ForwardB SHALL follow REQ-003..005 using RtID2EX.
REQ-007 Forward outputs SHALL be combinational, zero-latency.
REQ-008 Load-use hazard SHALL be the condition: MemReadID2EX && WriteRegisterID2EX!=0 && ((RsUsedIF2ID && RsIF2ID==WriteRegisterID2EX) || (RtUsedIF2ID && RtIF2ID==WriteRegisterID2EX)).
REQ-009 Scoreboard SHALL hold one LAT_W-bit down-counter per register; Pending[r] = (cnt[r]!=0).
REQ-010 Counter for register 0 SHALL be held at 0 permanently.
REQ-011 Legal issue SHALL be defined as: McIssue && !McBusy && McLat!=0.
REQ-012 On a legal issue with McDest!=0, cnt[McDest] SHALL load McLat at the next edge.
REQ-013 On a legal issue with McDest==0, the unit SHALL still occupy McBusy for McLat cycles via an internal busy counter, with no Pending bit set.
REQ-014 Every nonzero counter not being loaded SHALL decrement by 1 per cycle; there is no wrap below 0.
REQ-015 McBusy SHALL be 1 while the internal busy counter is nonzero; busy counter loads McLat on every legal issue.
REQ-016 Illegal issue (McIssue && (McBusy || McLat==0)) SHALL be ignored and SHALL set McIssueErr until reset.
REQ-017 Scoreboard hazard SHALL be the condition: (RsUsedIF2ID && RsIF2ID!=0 && Pending[RsIF2ID]) || same for Rt.
REQ-018 Stall SHALL be the combinational OR of load-use hazard and scoreboard hazard.
REQ-019 A load-use stall SHALL last exactly one cycle, because the bubble clears MemReadID2EX.
REQ-020 A scoreboard stall SHALL last until the counter reaches 0; Stall is 0 in the cycle cnt reads 0.
REQ-021 StallCount SHALL increment each cycle Stall==1, saturating at all-ones.
REQ-022 Issue and decrement in the same cycle on different registers SHALL both take effect.

Reset
REQ-023 On rst=1 at a rising edge: all counters, busy counter, McIssueErr and StallCount SHALL clear to 0.
REQ-024 After reset, McBusy=0 and Pending=0.
REQ-025 After reset, Forward*/Stall SHALL depend only on current inputs.
REQ-026 Reset mid-operation SHALL abandon all pending latencies immediately.
REQ-027 McIssue in the same cycle as rst SHALL be discarded.

Verification
REQ-028 Bench SHALL check: EX2MEM and MEM2WB both write r5, RsID2EX=5 -> ForwardA=1; with RegWriteEX2MEM=0 -> ForwardA=2; dest r0 -> 0.
REQ-029 Bench SHALL check: load to r8 in EX, RtIF2ID=8 with RtUsed=1 -> Stall=1 one cycle, StallCount=1; with RtUsed=0 -> Stall=0.
REQ-030 Bench SHALL check: McIssue dest r3 lat 4, then RsIF2ID=3 -> Stall=1 for 4 cycles, Pending[3] clears on the 4th edge, StallCount=4.
REQ-031 Bench SHALL check: second McIssue while McBusy, and McIssue with McLat=0 -> both ignored, McIssueErr=1 and held; McBusy timing unchanged.
REQ-032 Bench SHALL check: rst asserted 2 cycles into a lat-7 op -> next cycle Pending=0, McBusy=0, Stall=0, McIssueErr=0, StallCount=0.
REQ-033 Bench SHALL check: force Stall for 2**PERF_W+3 cycles -> StallCount saturates at all-ones, no wrap.
